face_detector: RTL and testbench

Streaming single-scale face detector for the emotion-classification pipeline. After a start pulse it accepts one raster-order grayscale frame and accumulates 8x8 block sums. It then scans every 24x24 (3x3-block) window with a three-band Haar-like "eyes/cheeks/mouth" feature and reports the best window as a face ROI. The downstream classifier consumes the ROI as face_x, face_y and a 24x24 size.

---
 rtl/face_detector.sv | 181 ++++++++++++++++++
 tb/tb_face_detector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/face_detector.sv
// face_detector
//   Streaming single-scale face detector. A start pulse opens a new frame.
//   One raster-order grayscale frame is accumulated into BLOCK_SIZE x BLOCK_SIZE
//   block sums. Every 3x3-block window is then scored with a three-band Haar-like
//   feature (2*middle - top - bottom), one window per cycle. The best window is
//   reported as a face ROI.
//
//   Ports:
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     start          one-cycle pulse, restarts frame capture from any state
//     pixel_in       unsigned pixel, raster order
//     pixel_valid    pixel_in valid this cycle (only honoured while capturing)
//     face_detected  best score strictly above THRESHOLD (valid while done)
//     face_x/face_y  top-left pixel of the best window, 0 when not detected
//     face_scale     window edge (3*BLOCK_SIZE) when detected, else 0
//     done           level, high from end of scan until start/rst
//
//   Optional feature macro FACE_DET_SCORE_OUT_EN adds output best_score
//   (signed winning score, valid while done, 0 otherwise).
//
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_CAPTURE | accumulating pixels into block sums
//   S_SCAN    | scoring one window per cycle, tracking the best
//   S_FINAL   | registering the result outputs
//   S_DONE    | results held until start/rst
module face_detector #(
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 64,
  parameter int PIXEL_WIDTH = 8,
  parameter int BLOCK_SIZE  = 8,
  parameter int THRESHOLD   = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid,
  output logic                   face_detected,
  output logic [7:0]             face_x,
  output logic [7:0]             face_y,
  output logic [7:0]             face_scale,
  output logic                   done
`ifdef FACE_DET_SCORE_OUT_EN
  ,
  output logic signed [PIXEL_WIDTH+2*$clog2(BLOCK_SIZE)+4:0] best_score
`endif
);

  localparam int LOG2B = $clog2(BLOCK_SIZE);
  localparam int NBX   = IMG_WIDTH / BLOCK_SIZE;
  localparam int NBY   = IMG_HEIGHT / BLOCK_SIZE;
  localparam int BW    = PIXEL_WIDTH + 2 * LOG2B;
  localparam int SW    = BW + 5;
  localparam int BXW   = $clog2(NBX);
  localparam int BYW   = $clog2(NBY);

  localparam logic signed [SW-1:0] SCORE_MIN = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0] THR       = SW'(THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SCAN,
    S_FINAL,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [BW-1:0]         blk [NBY][NBX];
  logic [7:0]            x, y;
  logic [BXW-1:0]        cap_bx, sbx, best_bx;
  logic [BYW-1:0]        cap_by, sby, best_by;
  logic                  last_pix, last_pos, det;
  logic signed [SW-1:0]  row_sum [3];
  logic signed [SW-1:0]  score, best;

  assign cap_bx   = BXW'(x >> LOG2B);
  assign cap_by   = BYW'(y >> LOG2B);
  assign last_pix = (x == 8'(IMG_WIDTH - 1)) && (y == 8'(IMG_HEIGHT - 1));
  assign last_pos = (sbx == BXW'(NBX - 3)) && (sby == BYW'(NBY - 3));
  assign det      = best > THR;

  // Row sums of the current 3x3-block window; block sums are unsigned and
  // zero-extend into the signed score width.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      row_sum[i] = '0;
      for (int j = 0; j < 3; j++) begin
        row_sum[i] = row_sum[i] + SW'(blk[sby + BYW'(i)][sbx + BXW'(j)]);
      end
    end
    score = (row_sum[1] <<< 1) - row_sum[0] - row_sum[2];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_CAPTURE;
    end else begin
      case (state)
        S_CAPTURE: if (pixel_valid && last_pix) state_nxt = S_SCAN;
        S_SCAN:    if (last_pos) state_nxt = S_FINAL;
        S_FINAL:   state_nxt = S_DONE;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int i = 0; i < NBY; i++)
        for (int j = 0; j < NBX; j++)
          blk[i][j] <= '0;
      x             <= '0;
      y             <= '0;
      sbx           <= '0;
      sby           <= '0;
      best          <= SCORE_MIN;
      best_bx       <= '0;
      best_by       <= '0;
      face_detected <= 1'b0;
      face_x        <= '0;
      face_y        <= '0;
      face_scale    <= '0;
      done          <= 1'b0;
`ifdef FACE_DET_SCORE_OUT_EN
      best_score    <= '0;
`endif
    end else begin
      case (state)
        S_CAPTURE: begin
          if (pixel_valid) begin
            blk[cap_by][cap_bx] <= blk[cap_by][cap_bx] + BW'(pixel_in);
            if (x == 8'(IMG_WIDTH - 1)) begin
              x <= '0;
              y <= y + 8'd1;
            end else begin
              x <= x + 8'd1;
            end
          end
        end
        S_SCAN: begin
          // Strictly greater keeps the earliest raster position on ties.
          if (score > best) begin
            best    <= score;
            best_bx <= sbx;
            best_by <= sby;
          end
          if (sbx == BXW'(NBX - 3)) begin
            sbx <= '0;
            sby <= sby + BYW'(1);
          end else begin
            sbx <= sbx + BXW'(1);
          end
        end
        S_FINAL: begin
          done          <= 1'b1;
          face_detected <= det;
          if (det) begin
            face_x     <= 8'(best_bx) << LOG2B;
            face_y     <= 8'(best_by) << LOG2B;
            face_scale <= 8'(3 * BLOCK_SIZE);
          end
`ifdef FACE_DET_SCORE_OUT_EN
          best_score    <= best;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_face_detector.sv
module tb_face_detector;

  logic       clk = 1'b0;
  logic       rst, start, pixel_valid;
  logic [7:0] pixel_in;
  logic       face_detected, done;
  logic [7:0] face_x, face_y, face_scale;
`ifdef FACE_DET_SCORE_OUT_EN
  logic signed [18:0] best_score;
`endif

  face_detector dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .face_detected(face_detected),
    .face_x(face_x), .face_y(face_y), .face_scale(face_scale), .done(done)
`ifdef FACE_DET_SCORE_OUT_EN
    , .best_score(best_score)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  bit exp_armed = 0;
  int exp_t = 0;
  int m_det, m_x, m_y, m_scale, m_score;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit in_face(input int fx, input int fy, input int bx, input int by);
    return (bx >= fx) && (bx <= fx + 2) && ((by == fy) || (by == fy + 2));
  endfunction

  // 0: uniform 0x80, 1: face at (3,2), 2: faces at (0,0) and (5,5), else 255
  function automatic int pixval(input int pat, input int x, input int y);
    int bx, by;
    bx = x / 8;
    by = y / 8;
    case (pat)
      0: return 128;
      1: return in_face(3, 2, bx, by) ? 50 : 200;
      2: return (in_face(0, 0, bx, by) || in_face(5, 5, bx, by)) ? 50 : 200;
      default: return 255;
    endcase
  endfunction

  task automatic model(input int pat);
    int bs[8][8];
    int best, bbx, bby, t, m, b, s;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        bs[i][j] = 0;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        bs[y/8][x/8] += pixval(pat, x, y);
    best = -(1 << 30);
    bbx = 0;
    bby = 0;
    for (int by = 0; by < 6; by++)
      for (int bx = 0; bx < 6; bx++) begin
        t = bs[by][bx] + bs[by][bx+1] + bs[by][bx+2];
        m = bs[by+1][bx] + bs[by+1][bx+1] + bs[by+1][bx+2];
        b = bs[by+2][bx] + bs[by+2][bx+1] + bs[by+2][bx+2];
        s = 2 * m - t - b;
        if (s > best) begin
          best = s;
          bbx = bx;
          bby = by;
        end
      end
    m_score = best;
    m_det   = (best > 4096) ? 1 : 0;
    m_x     = m_det ? bbx * 8 : 0;
    m_y     = m_det ? bby * 8 : 0;
    m_scale = m_det ? 24 : 0;
  endtask

  // Per-cycle comparison against the model: results appear exactly 37 edges
  // after the edge that accepted the last pixel; otherwise everything is 0.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_armed && (cyc >= exp_t + 37)) begin
        chk("done_high", int'(done), 1);
        chk("face_detected", int'(face_detected), m_det);
        chk("face_x", int'(face_x), m_x);
        chk("face_y", int'(face_y), m_y);
        chk("face_scale", int'(face_scale), m_scale);
`ifdef FACE_DET_SCORE_OUT_EN
        chk("best_score", int'(best_score), m_score);
`endif
      end else begin
        chk("done_low", int'(done), 0);
        chk("face_detected_idle", int'(face_detected), 0);
        chk("face_x_idle", int'(face_x), 0);
        chk("face_y_idle", int'(face_y), 0);
        chk("face_scale_idle", int'(face_scale), 0);
`ifdef FACE_DET_SCORE_OUT_EN
        chk("best_score_idle", int'(best_score), 0);
`endif
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    pixel_valid = 1'b1;
    pixel_in = 8'd255;
    @(posedge clk);
    #1 start = 1'b0;
    pixel_valid = 1'b0;
    exp_armed = 0;
  endtask

  task automatic do_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_armed = 0;
  endtask

  task automatic run_pixels(input int pat, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0 && (i % 64) == 0) begin
        repeat (3) begin
          @(posedge clk);
          #1 pixel_valid = 1'b0;
        end
      end
      @(posedge clk);
      #1 pixel_valid = 1'b1;
      pixel_in = 8'(pixval(pat, i % 64, i / 64));
    end
    @(posedge clk);
    #1 pixel_valid = 1'b0;
  endtask

  task automatic run_frame(input int pat, input bit stall);
    do_start();
    model(pat);
    run_pixels(pat, 4096, stall);
    exp_t = cyc;
    exp_armed = 1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic chk_face_24_16(input string tag);
    chk({tag, "_det"}, int'(face_detected), 1);
    chk({tag, "_x"}, int'(face_x), 24);
    chk({tag, "_y"}, int'(face_y), 16);
    chk({tag, "_scale"}, int'(face_scale), 24);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    chk("reset_done", int'(done), 0);
    chk("reset_det", int'(face_detected), 0);
    chk("reset_x", int'(face_x), 0);
    chk("reset_y", int'(face_y), 0);
    chk("reset_scale", int'(face_scale), 0);

    // pixels offered in IDLE are ignored
    repeat (20) begin
      @(posedge clk);
      #1 pixel_valid = 1'b1;
      pixel_in = 8'd255;
    end
    @(posedge clk);
    #1 pixel_valid = 1'b0;

    run_frame(0, 0);
    chk("uniform_model_score", m_score, 0);
    chk("uniform_done", int'(done), 1);
    chk("uniform_det", int'(face_detected), 0);
    chk("uniform_scale", int'(face_scale), 0);

    run_frame(1, 0);
    chk("face_model_score", m_score, 57600);
    chk("face_model_x", m_x, 24);
    chk_face_24_16("face");

    // pixel_valid in DONE must not disturb the held results
    repeat (10) begin
      @(posedge clk);
      #1 pixel_valid = 1'b1;
      pixel_in = 8'd255;
    end
    @(posedge clk);
    #1 pixel_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_face_24_16("done_hold");

    do_rst();
    chk("rst_done_x", int'(face_x), 0);
    chk("rst_done_scale", int'(face_scale), 0);

    run_frame(1, 1);
    chk_face_24_16("stall");

    run_frame(2, 0);
    chk("tie_model_score", m_score, 57600);
    chk("tie_det", int'(face_detected), 1);
    chk("tie_x", int'(face_x), 0);
    chk("tie_y", int'(face_y), 0);
    chk("tie_scale", int'(face_scale), 24);

    do_start();
    run_pixels(3, 1000, 0);
    do_rst();
    chk("midrst_done", int'(done), 0);
    run_frame(1, 0);
    chk_face_24_16("after_rst");

    do_start();
    run_pixels(3, 500, 0);
    run_frame(1, 0);
    chk_face_24_16("restart");

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
